// File: rtl/pipe_hazard_if.sv
// Handshake bundle between the 3-stage pipeline datapath and its hazard controller.
// The pipeline (master) presents FD decode fields and events; the controller (slave) returns stall/flush/forward controls.
interface pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic             fd_valid;
  logic [4:0]       fd_rs1;
  logic [4:0]       fd_rs2;
  logic             fd_use_rs1;
  logic             fd_use_rs2;
  logic [4:0]       fd_rd;
  logic             fd_reg_we;
  logic             fd_mem_to_reg;
  logic             ex_jump_taken;
  logic             mem_busy;
  logic             fd_stall;
  logic             fd_flush;
  logic             ex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output fd_valid, fd_rs1, fd_rs2, fd_use_rs1, fd_use_rs2, fd_rd,
           fd_reg_we, fd_mem_to_reg, ex_jump_taken, mem_busy,
    input  fd_stall, fd_flush, ex_bubble, fwd_a_sel, fwd_b_sel,
           ctrl_state, stall_cycles
  );

  modport slave (
    input  fd_valid, fd_rs1, fd_rs2, fd_use_rs1, fd_use_rs2, fd_rd,
           fd_reg_we, fd_mem_to_reg, ex_jump_taken, mem_busy,
    output fd_stall, fd_flush, ex_bubble, fwd_a_sel, fwd_b_sel,
           ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the FD/EX/MW pipeline: slot tracking, load-use stall,
// jump flush, memory-busy hold, EX operand forwarding and a stall-cycle counter.
//
//  state  | meaning
//  RUN    | no hazard, all controls idle
//  LSTALL | load-use: hold FD one cycle, bubble into EX
//  FLUSH  | taken jump: squash FD and bubble EX for JUMP_PENALTY cycles
//  HOLD   | data memory busy: whole pipe frozen, previous state resumes after
module pipe_hazard_ctrl #(
  parameter int JUMP_PENALTY = 1,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_HOLD   = 2'b11
  } state_e;

  localparam logic [1:0] PENALTY = 2'(JUMP_PENALTY);

  // Only RUN and FLUSH persist across edges; LSTALL and HOLD are decided in the cycle
  // they occur, so ctrl_state reports the state in force this cycle (state_eff).
  state_e     state_q, state_d, state_eff;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       ex_v_q, ex_v_d;
  logic [4:0] ex_rs1_q, ex_rs1_d;
  logic [4:0] ex_rs2_q, ex_rs2_d;
  logic       ex_use1_q, ex_use1_d;
  logic       ex_use2_q, ex_use2_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_we_q, ex_we_d;
  logic       ex_ld_q, ex_ld_d;

  logic       mw_v_q, mw_v_d;
  logic [4:0] mw_rd_q, mw_rd_d;
  logic       mw_we_q, mw_we_d;
  logic       mw_ld_q, mw_ld_d;

  logic       wb_v_q, wb_v_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic       wb_we_q, wb_we_d;

  logic       load_use;
  logic       stall, flush, bubble;
  logic [1:0] fwd_a, fwd_b;

  assign load_use = ex_v_q && ex_ld_q && ex_we_q && hz.fd_valid &&
                    ((hz.fd_use_rs1 && (hz.fd_rs1 == ex_rd_q)) ||
                     (hz.fd_use_rs2 && (hz.fd_rs2 == ex_rd_q)));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    state_eff   = ST_RUN;
    stall       = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    if (hz.mem_busy) begin
      state_eff = ST_HOLD;
      stall     = 1'b1;
    end else if (hz.ex_jump_taken) begin
      // flush_cnt holds the flush cycles still owed after the current one
      state_eff   = ST_FLUSH;
      flush       = 1'b1;
      bubble      = 1'b1;
      flush_cnt_d = PENALTY - 2'd1;
      state_d     = (PENALTY > 2'd1) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      state_eff   = ST_FLUSH;
      flush       = 1'b1;
      bubble      = 1'b1;
      flush_cnt_d = (flush_cnt_q != 2'd0) ? flush_cnt_q - 2'd1 : 2'd0;
      state_d     = (flush_cnt_q > 2'd1) ? ST_FLUSH : ST_RUN;
    end else if (load_use) begin
      state_eff = ST_LSTALL;
      stall     = 1'b1;
      bubble    = 1'b1;
      state_d   = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    ex_v_d   = ex_v_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    ex_use1_d = ex_use1_q;
    ex_use2_d = ex_use2_q;
    ex_rd_d  = ex_rd_q;
    ex_we_d  = ex_we_q;
    ex_ld_d  = ex_ld_q;
    mw_v_d   = mw_v_q;
    mw_rd_d  = mw_rd_q;
    mw_we_d  = mw_we_q;
    mw_ld_d  = mw_ld_q;
    wb_v_d   = wb_v_q;
    wb_rd_d  = wb_rd_q;
    wb_we_d  = wb_we_q;
    if (!hz.mem_busy) begin
      wb_v_d    = mw_v_q;
      wb_rd_d   = mw_rd_q;
      wb_we_d   = mw_we_q;
      mw_v_d    = ex_v_q;
      mw_rd_d   = ex_rd_q;
      mw_we_d   = ex_we_q;
      mw_ld_d   = ex_ld_q;
      ex_v_d    = hz.fd_valid && !bubble;
      ex_rs1_d  = hz.fd_rs1;
      ex_rs2_d  = hz.fd_rs2;
      ex_use1_d = hz.fd_use_rs1;
      ex_use2_d = hz.fd_use_rs2;
      ex_rd_d   = hz.fd_rd;
      // r0 writes are dropped here so r0 never matches as a hazard or forward source
      ex_we_d   = hz.fd_reg_we && (hz.fd_rd != 5'd0);
      ex_ld_d   = hz.fd_mem_to_reg;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_use1_q && mw_v_q && mw_we_q && !mw_ld_q && (mw_rd_q == ex_rs1_q)) begin
      fwd_a = 2'b01;
    end else if (ex_use1_q && wb_v_q && wb_we_q && (wb_rd_q == ex_rs1_q)) begin
      fwd_a = 2'b10;
    end
    if (ex_use2_q && mw_v_q && mw_we_q && !mw_ld_q && (mw_rd_q == ex_rs2_q)) begin
      fwd_b = 2'b01;
    end else if (ex_use2_q && wb_v_q && wb_we_q && (wb_rd_q == ex_rs2_q)) begin
      fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      stall_cnt_q <= '0;
      ex_v_q      <= 1'b0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_use1_q   <= 1'b0;
      ex_use2_q   <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mw_v_q      <= 1'b0;
      mw_rd_q     <= 5'd0;
      mw_we_q     <= 1'b0;
      mw_ld_q     <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      ex_v_q      <= ex_v_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_use1_q   <= ex_use1_d;
      ex_use2_q   <= ex_use2_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mw_v_q      <= mw_v_d;
      mw_rd_q     <= mw_rd_d;
      mw_we_q     <= mw_we_d;
      mw_ld_q     <= mw_ld_d;
      wb_v_q      <= wb_v_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
    end
  end

  assign hz.fd_stall     = stall;
  assign hz.fd_flush     = flush;
  assign hz.ex_bubble    = bubble;
  assign hz.fwd_a_sel    = fwd_a;
  assign hz.fwd_b_sel    = fwd_b;
  assign hz.ctrl_state   = state_eff;
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, jump flush, busy hold,
// r0 handling, async reset and stall counter saturation.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  pipe_hazard_if #(.CNT_W(CW)) hif ();

  pipe_hazard_ctrl #(.JUMP_PENALTY(2), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fd_stall, fd_flush, ex_bubble, ctrl_state}: RUN 00000, LSTALL 10101, FLUSH 01110, HOLD 10011
  logic [4:0] ctl;
  logic [3:0] fwd;
  assign ctl = {hif.fd_stall, hif.fd_flush, hif.ex_bubble, hif.ctrl_state};
  assign fwd = {hif.fwd_a_sel, hif.fwd_b_sel};

  // A real EX instruction must never see a matching load still in MW
  always @(negedge clk) begin
    if (rst_n && dut.ex_v_q && dut.mw_v_q && dut.mw_ld_q && dut.mw_we_q &&
        ((dut.ex_use1_q && dut.ex_rs1_q == dut.mw_rd_q) ||
         (dut.ex_use2_q && dut.ex_rs2_q == dut.mw_rd_q))) begin
      n_mis++;
      $display("FAIL mw_load_match: EX rs matches MW load rd %0d", dut.mw_rd_q);
    end
  end

  task automatic set_fd(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    hif.fd_valid      = v;
    hif.fd_rs1        = rs1;
    hif.fd_rs2        = rs2;
    hif.fd_use_rs1    = u1;
    hif.fd_use_rs2    = u2;
    hif.fd_rd         = rd;
    hif.fd_reg_we     = we;
    hif.fd_mem_to_reg = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    hif.ex_jump_taken = 1'b0;
    hif.mem_busy      = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL rst_ctl: got %b want %b", ctl, 5'b00000); end
    n_cmp++; if (fwd !== 4'b0000) begin n_mis++; $display("FAIL rst_fwd: got %b want %b", fwd, 4'b0000); end
    n_cmp++; if (hif.stall_cycles !== 4'd0) begin n_mis++; $display("FAIL rst_cnt: got %0d want 0", hif.stall_cycles); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    drain();
    set_fd(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);      // add r3 <- r1, r2
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL b2b_ctl0: got %b want %b", ctl, 5'b00000); end
    tick();
    set_fd(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);      // sub r4 <- r3, r5
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL b2b_ctl1: got %b want %b", ctl, 5'b00000); end
    tick();
    set_fd(1, 5'd5, 5'd3, 1, 1, 5'd8, 1, 0);      // or r8 <- r5, r3
    #1;
    n_cmp++; if (fwd !== 4'b0100) begin n_mis++; $display("FAIL b2b_fwd_mw: got %b want %b", fwd, 4'b0100); end
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL b2b_nostall: got %b want %b", ctl, 5'b00000); end
    tick();
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (fwd !== 4'b0010) begin n_mis++; $display("FAIL b2b_fwd_wb: got %b want %b", fwd, 4'b0010); end
    n_cmp++; if (hif.stall_cycles !== 4'd0) begin n_mis++; $display("FAIL b2b_cnt: got %0d want 0", hif.stall_cycles); end
  endtask

  task automatic test_fwd_priority();
    drain();
    set_fd(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0);      // addi r3
    tick();
    set_fd(1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 0);      // addi r3 again
    tick();
    set_fd(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);      // sub r4 <- r3, r3
    tick();
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (fwd !== 4'b0101) begin n_mis++; $display("FAIL prio_fwd: got %b want %b", fwd, 4'b0101); end
  endtask

  task automatic test_load_use();
    drain();
    set_fd(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1);      // lw r6
    tick();
    set_fd(1, 5'd6, 5'd6, 1, 1, 5'd7, 1, 0);      // add r7 <- r6, r6
    #1;
    n_cmp++; if (ctl !== 5'b10101) begin n_mis++; $display("FAIL lu_ctl: got %b want %b", ctl, 5'b10101); end
    tick();
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL lu_release: got %b want %b", ctl, 5'b00000); end
    n_cmp++; if (hif.stall_cycles !== 4'd1) begin n_mis++; $display("FAIL lu_cnt: got %0d want 1", hif.stall_cycles); end
    tick();
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (fwd !== 4'b1010) begin n_mis++; $display("FAIL lu_fwd_wb: got %b want %b", fwd, 4'b1010); end
  endtask

  task automatic test_jump();
    drain();
    set_fd(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0);
    hif.ex_jump_taken = 1'b1;
    #1;
    n_cmp++; if (ctl !== 5'b01110) begin n_mis++; $display("FAIL jmp_c0: got %b want %b", ctl, 5'b01110); end
    tick();
    hif.ex_jump_taken = 1'b0;
    #1;
    n_cmp++; if (ctl !== 5'b01110) begin n_mis++; $display("FAIL jmp_c1: got %b want %b", ctl, 5'b01110); end
    tick();
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL jmp_end: got %b want %b", ctl, 5'b00000); end
    n_cmp++; if (hif.stall_cycles !== 4'd1) begin n_mis++; $display("FAIL jmp_cnt: got %0d want 1", hif.stall_cycles); end
  endtask

  task automatic test_busy_in_flush();
    drain();
    hif.ex_jump_taken = 1'b1;
    tick();
    hif.ex_jump_taken = 1'b0;
    hif.mem_busy      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ctl !== 5'b10011) begin n_mis++; $display("FAIL hold_c%0d: got %b want %b", i, ctl, 5'b10011); end
      tick();
    end
    hif.mem_busy = 1'b0;
    #1;
    n_cmp++; if (ctl !== 5'b01110) begin n_mis++; $display("FAIL hold_resume: got %b want %b", ctl, 5'b01110); end
    n_cmp++; if (hif.stall_cycles !== 4'd4) begin n_mis++; $display("FAIL hold_cnt: got %0d want 4", hif.stall_cycles); end
    tick();
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL hold_end: got %b want %b", ctl, 5'b00000); end
  endtask

  task automatic test_r0_and_jump_lu();
    drain();
    set_fd(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);      // add r0 <- r1, r2
    tick();
    set_fd(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0);      // sub r4 <- r0, r0
    tick();
    set_fd(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);      // lw r0
    #1;
    n_cmp++; if (fwd !== 4'b0000) begin n_mis++; $display("FAIL r0_fwd: got %b want %b", fwd, 4'b0000); end
    tick();
    set_fd(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0);      // add r7 <- r0, r0
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL r0_lu: got %b want %b", ctl, 5'b00000); end
    tick();
    set_fd(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1);      // lw r6
    tick();
    set_fd(1, 5'd6, 5'd6, 1, 1, 5'd7, 1, 0);      // add r7 <- r6, r6 with jump taken
    hif.ex_jump_taken = 1'b1;
    #1;
    n_cmp++; if (ctl !== 5'b01110) begin n_mis++; $display("FAIL jlu_ctl: got %b want %b", ctl, 5'b01110); end
    tick();
    hif.ex_jump_taken = 1'b0;
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (ctl !== 5'b01110) begin n_mis++; $display("FAIL jlu_c1: got %b want %b", ctl, 5'b01110); end
    tick();
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL jlu_end: got %b want %b", ctl, 5'b00000); end
    n_cmp++; if (hif.stall_cycles !== 4'd4) begin n_mis++; $display("FAIL jlu_cnt: got %0d want 4", hif.stall_cycles); end
  endtask

  task automatic test_reset_mid_lstall();
    drain();
    set_fd(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1);      // lw r6
    tick();
    set_fd(1, 5'd6, 5'd0, 1, 0, 5'd7, 1, 0);      // add r7 <- r6
    #1;
    n_cmp++; if (ctl !== 5'b10101) begin n_mis++; $display("FAIL rlu_pre: got %b want %b", ctl, 5'b10101); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL rlu_ctl: got %b want %b", ctl, 5'b00000); end
    n_cmp++; if (hif.stall_cycles !== 4'd0) begin n_mis++; $display("FAIL rlu_cnt: got %0d want 0", hif.stall_cycles); end
    n_cmp++; if (fwd !== 4'b0000) begin n_mis++; $display("FAIL rlu_fwd: got %b want %b", fwd, 4'b0000); end
    #2 rst_n = 1'b1;
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_fd(1, 5'd6, 5'd0, 1, 0, 5'd7, 1, 0);
    #1;
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL rlu_after: got %b want %b", ctl, 5'b00000); end
  endtask

  task automatic test_saturation();
    drain();
    hif.mem_busy = 1'b1;
    repeat (17) tick();
    #1;
    n_cmp++; if (hif.stall_cycles !== 4'hF) begin n_mis++; $display("FAIL sat_cnt: got %0d want 15", hif.stall_cycles); end
    n_cmp++; if (ctl !== 5'b10011) begin n_mis++; $display("FAIL sat_ctl: got %b want %b", ctl, 5'b10011); end
    hif.mem_busy = 1'b0;
    tick();
    #1;
    n_cmp++; if (hif.stall_cycles !== 4'hF) begin n_mis++; $display("FAIL sat_hold: got %0d want 15", hif.stall_cycles); end
    n_cmp++; if (ctl !== 5'b00000) begin n_mis++; $display("FAIL sat_end: got %b want %b", ctl, 5'b00000); end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    set_fd(0, 0, 0, 0, 0, 0, 0, 0);
    hif.ex_jump_taken = 1'b0;
    hif.mem_busy      = 1'b0;
    test_reset();
    test_back_to_back();
    test_fwd_priority();
    test_load_use();
    test_jump();
    test_busy_in_flush();
    test_r0_and_jump_lu();
    test_reset_mid_lstall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
